ysyx_25060170_ifu: RTL and testbench
====================================

# ysyx_25060170_ifu

Instruction fetch unit of the single-issue ysyx_25060170 core; sits directly upstream of the decode stage. It owns the architectural PC and issues one word fetch per instruction over a valid/ready instruction-memory port. It presents `{pc, inst}` to decode with a valid/ready handshake, then waits for write-back to report the next-PC decision (sequential or jump) before fetching again. It holds a sticky fault flag for bus errors and misaligned targets.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000: PC loaded on reset.
- `XLEN`, 32: address/data width; only 32 is supported.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req_valid_o`  out  1  fetch request valid.
- `imem_req_ready_i`  in  1  memory accepts request.
- `imem_req_addr_o`  out  32  word address; equals current PC.
- `imem_rsp_valid_i`  in  1  response valid.
- `imem_rsp_data_i`  in  32  instruction word.
- `imem_rsp_err_i`  in  1  bus error; qualified by `imem_rsp_valid_i`.
- `pc_o`  out  32  PC of the presented instruction.
- `inst_o`  out  32  presented instruction.
- `inst_valid_o`  out  1  `{pc_o, inst_o}` valid to decode.
- `id_ready_i`  in  1  decode accepts.
- `wb_valid_i`  in  1  write-back commit of the outstanding instruction.
- `wb_jump_en_i`  in  1  commit redirects the PC.
- `wb_jump_target_i`  in  32  redirect target.
- `fetch_fault_o`  out  1  sticky fault; the unit halts.
- `inst_cnt_o`  out  32  number of instructions accepted by decode; wraps at 2^32.

## Operation
- Five states: `RST_HOLD`, `REQ`, `WAIT_RSP`, `DELIVER`, `WAIT_WB`, plus a terminal `FAULT`.
- `RST_HOLD` is entered on reset and left on the first clock edge with `rst` low; the next state is `REQ`.
- `REQ`:
  - `imem_req_valid_o` is 1 and `imem_req_addr_o` = PC.
  - The address is held stable until `imem_req_valid_o & imem_req_ready_i`.
  - On that request fire, go to `WAIT_RSP`.
- `WAIT_RSP`:
  - The unit is always ready for the response; there is no ready output.
  - On `imem_rsp_valid_i` with `imem_rsp_err_i` low: latch `imem_rsp_data_i` into `inst_o` and go to `DELIVER`.
  - On `imem_rsp_valid_i` with `imem_rsp_err_i` high: go to `FAULT`.
- `DELIVER`:
  - `inst_valid_o` is 1.
  - `pc_o` and `inst_o` are held stable until `id_ready_i`.
  - On the accept handshake: `inst_cnt_o` += 1 and go to `WAIT_WB`.
- `WAIT_WB`, on `wb_valid_i`:
  - next PC = `wb_jump_en_i ? {wb_jump_target_i[31:1],1'b0} : PC + 4`, computed mod 2^32 (0xFFFF_FFFC + 4 = 0).
  - If next PC[1] is 1, go to `FAULT`; otherwise go to `REQ`.
- `FAULT`:
  - `fetch_fault_o` = 1.
  - All valid outputs are 0.
  - The PC is frozen at the faulting address.
  - Only reset exits this state.
- Responses arriving outside `WAIT_RSP` are dropped. This covers stale responses after reset.
- `wb_valid_i` outside `WAIT_WB` is ignored.

## Timing
- Reset values:
  - PC = `RESET_PC`.
  - `inst_o` = 32'h0000_0013 (nop).
  - `inst_valid_o`, `imem_req_valid_o`, `fetch_fault_o` = 0.
  - `inst_cnt_o` = 0.
  - `imem_req_addr_o` = `RESET_PC`.
- Reset asserted mid-operation aborts immediately, in any state, including an outstanding request.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- A response is never taken in the same cycle as its request fire. The earliest response cycle is the one after fire.
- Best-case loop is 4 cycles per instruction:
  - `REQ` fire in cycle N;
  - response in N+1;
  - decode accept in N+2;
  - write-back in N+3;
  - next `REQ` in N+4.
- After the reset release edge, the first `imem_req_valid_o` appears one cycle later.

## Structure
- Shared package `ysyx_25060170_pkg`: `RESET_PC` default, `NOP_INST` constant, and the `ifu_state_t` enum.
- One sub-module, `ysyx_25060170_pc_gen`: a combinational next-PC calculation plus the misalignment check. It is reused by the branch unit later.
- Everything else stays flat in the top.

## Test plan
- **Reset then stall-free fetch:** responses 0x00000413 and 0x00100513, `wb_jump_en_i` = 0 → `pc_o` = 0x80000000 then 0x80000004; `inst_cnt_o` = 2; 4 cycles apart.
- **Backpressure:** `imem_req_ready_i` low for 3 cycles, then `id_ready_i` low for 5 cycles → the address and `pc_o`/`inst_o` hold stable, with no duplicate requests or counts.
- **Jump:**
  - jalr commit with target 0x80000101 → next request address 0x80000100.
  - target 0x80000102 → `fetch_fault_o` = 1 and no further requests.
- **Bus error:** `imem_rsp_err_i` = 1 at PC 0x80000008 → `FAULT`; `inst_valid_o` never asserted; `inst_cnt_o` unchanged.
- **Reset mid-`WAIT_RSP`:**
  - Assert `rst`, then deliver a stale response after release → it is dropped.
  - The fetch restarts at 0x80000000 with `inst_cnt_o` = 0.
- **Wrap-around:** `RESET_PC` = 0xFFFFFFFC with a sequential commit → next request address 0x00000000; `inst_cnt_o` preloaded to 0xFFFFFFFF wraps to 0 on the next accept.

Source files
------------

// File: rtl/ysyx_25060170_pkg.sv
// Shared definitions for the ysyx_25060170 fetch path: reset PC, the NOP word
// and the IFU state encoding.
package ysyx_25060170_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    DELIVER  = 3'd3,
    WAIT_WB  = 3'd4,
    FAULT    = 3'd5
  } ifu_state_t;

endpackage

// File: rtl/ysyx_25060170_pc_gen.sv
// Next-PC selection (sequential or redirect) with the halfword-misalignment check.
// Purely combinational so the branch unit can share it.
module ysyx_25060170_pc_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);

  // Bit 0 of a jalr target is architecturally discarded.
  logic unused_target_lsb;
  assign unused_target_lsb = jump_target_i[0];

  assign next_pc_o    = jump_en_i ? {jump_target_i[XLEN-1:1], 1'b0} : pc_i + XLEN'(4);
  assign misaligned_o = next_pc_o[1];

endmodule

// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit: one word fetch per instruction, presents {pc, inst}
// to decode, then waits for write-back to choose the next PC.
module ysyx_25060170_ifu
  import ysyx_25060170_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned XLEN      = 32,
  // Counter reset value; lets a harness start near the wrap point.
  parameter logic [31:0] CNT_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            inst_valid_o,
  input  logic            id_ready_i,
  input  logic            wb_valid_i,
  input  logic            wb_jump_en_i,
  input  logic [XLEN-1:0] wb_jump_target_i,
  output logic            fetch_fault_o,
  output logic [XLEN-1:0] inst_cnt_o
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; valid and its payload hold stable until then.

  ifu_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  ysyx_25060170_pc_gen #(.XLEN(XLEN)) u_pc_gen (
    .pc_i          (pc_q),
    .jump_en_i     (wb_jump_en_i),
    .jump_target_i (wb_jump_target_i),
    .next_pc_o     (next_pc),
    .misaligned_o  (next_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST_HOLD: state_d = REQ;
      REQ:      if (imem_req_ready_i) state_d = WAIT_RSP;
      WAIT_RSP: if (imem_rsp_valid_i) state_d = imem_rsp_err_i ? FAULT : DELIVER;
      DELIVER:  if (id_ready_i) state_d = WAIT_WB;
      WAIT_WB:  if (wb_valid_i) state_d = next_misaligned ? FAULT : REQ;
      FAULT:    state_d = FAULT;
      default:  state_d = FAULT;
    endcase
  end

  always_comb begin
    imem_req_valid_o = 1'b0;
    inst_valid_o     = 1'b0;
    fetch_fault_o    = 1'b0;
    unique case (state_q)
      REQ:     imem_req_valid_o = 1'b1;
      DELIVER: inst_valid_o     = 1'b1;
      FAULT:   fetch_fault_o    = 1'b1;
      default: ;
    endcase
  end

  // A misaligned redirect still updates the PC so it freezes at the bad target.
  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    cnt_d  = cnt_q;
    if (state_q == WAIT_RSP && imem_rsp_valid_i && !imem_rsp_err_i) inst_d = imem_rsp_data_i;
    if (state_q == DELIVER && id_ready_i) cnt_d = cnt_q + XLEN'(1);
    if (state_q == WAIT_WB && wb_valid_i) pc_d = next_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      inst_q <= NOP_INST;
      cnt_q  <= CNT_RESET;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
      cnt_q  <= cnt_d;
    end
  end

  assign imem_req_addr_o = pc_q;
  assign pc_o            = pc_q;
  assign inst_o          = inst_q;
  assign inst_cnt_o      = cnt_q;

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Bench for ysyx_25060170_ifu: directed fetch sequences with a scoreboard of
// expected request addresses and deliveries, plus a second instance for wrap-around.
module tb_ysyx_25060170_ifu;

  logic        clk, rst;
  logic        req_ready, rsp_valid, rsp_err, id_ready, wb_valid, wb_jump_en;
  logic [31:0] rsp_data, wb_target;
  logic        req_valid, inst_valid, fault;
  logic [31:0] req_addr, pc, inst, cnt;

  logic        w_req_ready, w_rsp_valid, w_rsp_err, w_id_ready, w_wb_valid, w_wb_jump_en;
  logic [31:0] w_rsp_data, w_wb_target;
  logic        w_req_valid, w_inst_valid, w_fault;
  logic [31:0] w_req_addr, w_pc, w_inst, w_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [31:0] exp_req_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  int          fire_cyc_q[$];

  ysyx_25060170_ifu dut (
    .clk (clk), .rst (rst),
    .imem_req_valid_o (req_valid), .imem_req_ready_i (req_ready), .imem_req_addr_o (req_addr),
    .imem_rsp_valid_i (rsp_valid), .imem_rsp_data_i (rsp_data), .imem_rsp_err_i (rsp_err),
    .pc_o (pc), .inst_o (inst), .inst_valid_o (inst_valid), .id_ready_i (id_ready),
    .wb_valid_i (wb_valid), .wb_jump_en_i (wb_jump_en), .wb_jump_target_i (wb_target),
    .fetch_fault_o (fault), .inst_cnt_o (cnt)
  );

  ysyx_25060170_ifu #(.RESET_PC(32'hFFFF_FFFC), .CNT_RESET(32'hFFFF_FFFF)) dut_w (
    .clk (clk), .rst (rst),
    .imem_req_valid_o (w_req_valid), .imem_req_ready_i (w_req_ready), .imem_req_addr_o (w_req_addr),
    .imem_rsp_valid_i (w_rsp_valid), .imem_rsp_data_i (w_rsp_data), .imem_rsp_err_i (w_rsp_err),
    .pc_o (w_pc), .inst_o (w_inst), .inst_valid_o (w_inst_valid), .id_ready_i (w_id_ready),
    .wb_valid_i (w_wb_valid), .wb_jump_en_i (w_wb_jump_en), .wb_jump_target_i (w_wb_target),
    .fetch_fault_o (w_fault), .inst_cnt_o (w_cnt)
  );

  // Clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = req_valid, 1 = inst_valid
  task automatic wait_for(input int which, input string name);
    int n = 0;
    while (!(which == 0 ? req_valid : inst_valid) && n < 50) begin
      step();
      n++;
    end
    if (!(which == 0 ? req_valid : inst_valid)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got 0 after 50 cycles, expected 1", name);
    end
  endtask

  // Monitor: pops the scoreboard on every request fire and every decode accept
  always @(negedge clk) begin
    if (req_valid && req_ready) begin
      fire_cyc_q.push_back(cyc);
      if (exp_req_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_req: got request at %h, expected none", req_addr);
      end else begin
        check("req_addr", req_addr, exp_req_q.pop_front());
      end
    end
    if (inst_valid && id_ready) begin
      if (exp_pc_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_accept: got pc %h, expected none", pc);
      end else begin
        check("deliver_pc", pc, exp_pc_q.pop_front());
        check("deliver_inst", inst, exp_inst_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic idle_inputs();
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_data = 32'h0;
    id_ready = 1'b0; wb_valid = 1'b0; wb_jump_en = 1'b0; wb_target = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_req_valid", {31'b0, req_valid}, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'h0);
    check("rst_cnt", cnt, 32'h0);
    check("rst_addr", req_addr, 32'h8000_0000);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_inst", inst, 32'h0000_0013);
    rst = 1'b0;
    check("hold_req_valid", {31'b0, req_valid}, 32'h0);
    step();
    check("first_req_valid", {31'b0, req_valid}, 32'h1);
  endtask

  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input int req_stall,
                           input int id_stall, input logic jmp, input logic [31:0] tgt);
    exp_req_q.push_back(addr);
    exp_pc_q.push_back(addr);
    exp_inst_q.push_back(data);
    wait_for(0, "req_wait");
    for (int i = 0; i < req_stall; i++) begin
      rsp_valid = 1'b1;
      rsp_data  = 32'hBAD0_0000 | 32'(i);
      step();
      check("req_addr_hold", req_addr, addr);
      check("req_valid_hold", {31'b0, req_valid}, 32'h1);
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_err   = 1'b0;
    rsp_data  = data;
    step();
    rsp_valid = 1'b0;
    wait_for(1, "inst_wait");
    for (int i = 0; i < id_stall; i++) begin
      wb_valid   = 1'b1;
      wb_jump_en = 1'b1;
      wb_target  = 32'h1234_5678;
      step();
      check("pc_hold", pc, addr);
      check("inst_hold", inst, data);
    end
    wb_valid   = 1'b0;
    wb_jump_en = 1'b0;
    id_ready   = 1'b1;
    step();
    id_ready   = 1'b0;
    wb_valid   = 1'b1;
    wb_jump_en = jmp;
    wb_target  = tgt;
    step();
    wb_valid   = 1'b0;
    wb_jump_en = 1'b0;
  endtask

  task automatic fetch_err(input logic [31:0] addr);
    exp_req_q.push_back(addr);
    wait_for(0, "req_wait_err");
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_err   = 1'b1;
    rsp_data  = 32'hFFFF_FFFF;
    step();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_err = 1'b0; w_rsp_data = 32'h0;
    w_id_ready = 1'b0; w_wb_valid = 1'b0; w_wb_jump_en = 1'b0; w_wb_target = 32'h0;

    // Stall-free fetch
    do_reset();
    fire_cyc_q.delete();
    fetch_one(32'h8000_0000, 32'h0000_0413, 0, 0, 1'b0, 32'h0);
    fetch_one(32'h8000_0004, 32'h0010_0513, 0, 0, 1'b0, 32'h0);
    check("cnt_after_two", cnt, 32'd2);
    if (fire_cyc_q.size() >= 2) check("fire_gap", 32'(fire_cyc_q[1] - fire_cyc_q[0]), 32'd4);
    else check("fire_count", 32'(fire_cyc_q.size()), 32'd2);

    // Backpressure on both sides
    fetch_one(32'h8000_0008, 32'h0000_0593, 3, 5, 1'b0, 32'h0);
    check("cnt_after_stall", cnt, 32'd3);

    // Jumps: odd target is cleared, bit1 target faults
    fetch_one(32'h8000_000C, 32'h0000_8067, 0, 0, 1'b1, 32'h8000_0101);
    check("jump_addr", req_addr, 32'h8000_0100);
    fetch_one(32'h8000_0100, 32'h0000_80E7, 0, 0, 1'b1, 32'h8000_0102);
    check("mis_fault", {31'b0, fault}, 32'h1);
    check("mis_pc_frozen", req_addr, 32'h8000_0102);
    check("mis_cnt", cnt, 32'd5);
    for (int i = 0; i < 5; i++) begin
      req_ready = 1'b1;
      step();
      check("mis_no_req", {31'b0, req_valid}, 32'h0);
      check("mis_fault_sticky", {31'b0, fault}, 32'h1);
    end
    req_ready = 1'b0;

    // Bus error at the third fetch
    do_reset();
    fetch_one(32'h8000_0000, 32'h0000_0413, 0, 0, 1'b0, 32'h0);
    fetch_one(32'h8000_0004, 32'h0010_0513, 0, 0, 1'b0, 32'h0);
    fetch_err(32'h8000_0008);
    check("err_fault", {31'b0, fault}, 32'h1);
    check("err_cnt", cnt, 32'd2);
    check("err_pc_frozen", req_addr, 32'h8000_0008);
    for (int i = 0; i < 4; i++) begin
      id_ready = 1'b1;
      step();
      check("err_no_inst_valid", {31'b0, inst_valid}, 32'h0);
    end
    id_ready = 1'b0;

    // Reset while a response is outstanding; stale response must be dropped
    do_reset();
    fetch_one(32'h8000_0000, 32'h0000_0413, 0, 0, 1'b0, 32'h0);
    exp_req_q.push_back(32'h8000_0004);
    wait_for(0, "req_wait_abort");
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rst = 1'b1;
    step();
    check("abort_cnt", cnt, 32'h0);
    check("abort_inst_valid", {31'b0, inst_valid}, 32'h0);
    rst = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEAD_BEEF;
    step();
    check("restart_req_valid", {31'b0, req_valid}, 32'h1);
    check("restart_addr", req_addr, 32'h8000_0000);
    step();
    rsp_valid = 1'b0;
    check("stale_dropped", inst, 32'h0000_0013);
    fetch_one(32'h8000_0000, 32'h0000_0613, 0, 0, 1'b0, 32'h0);
    check("restart_cnt", cnt, 32'd1);

    // Wrap-around instance (sitting in REQ since the last reset)
    check("w_req_valid", {31'b0, w_req_valid}, 32'h1);
    check("w_addr", w_req_addr, 32'hFFFF_FFFC);
    check("w_cnt_preload", w_cnt, 32'hFFFF_FFFF);
    w_req_ready = 1'b1;
    step();
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b1;
    w_rsp_data  = 32'h0000_0013;
    step();
    w_rsp_valid = 1'b0;
    check("w_inst_valid", {31'b0, w_inst_valid}, 32'h1);
    check("w_pc", w_pc, 32'hFFFF_FFFC);
    w_id_ready = 1'b1;
    step();
    w_id_ready = 1'b0;
    check("w_cnt_wrap", w_cnt, 32'h0);
    w_wb_valid = 1'b1;
    step();
    w_wb_valid = 1'b0;
    check("w_next_valid", {31'b0, w_req_valid}, 32'h1);
    check("w_next_addr", w_req_addr, 32'h0);
    check("w_no_fault", {31'b0, w_fault}, 32'h0);

    // Final report
    step();
    check("req_q_empty", 32'(exp_req_q.size()), 32'h0);
    check("deliver_q_empty", 32'(exp_pc_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
